// File: rtl/dds_bus_responder.sv
// DDS bus responder: slave side of an asynchronous parallel DDS register bus.
// Bus pins are resynchronised into the clock domain. Writes land in a 64-word
// buffer bank, and a rising edge on dds_FUD copies that bank into the active bank.
// Reads return words from the active bank.
//
// Ports:
//   clock, reset      responder clock; asynchronous active-high reset
//   dds_addr          bus byte address (word index = addr[6:1])
//   dds_data_I        bus write data
//   dds_data_O        bus read data, registered
//   dds_data_T        0 = drive dds_data_O, 1 = high-Z
//   dds_control       {dds_reset, r_strobe_n, w_strobe_n}
//   dds_cs_n          board select, active low
//   dds_FUD           IO update; rising edge loads the active bank
//   ftw, ptw, asf     active-bank words at byte addresses 0x2F/0x2D, 0x31, 0x33
//   update_pulse      one-clock pulse when the active bank is loaded
//   proto_err         sticky: both strobes seen low while selected
//   wr_count          saturating count of accepted writes
module dds_bus_responder #(
  parameter int unsigned U_DDS_DATA_WIDTH = 16,
  parameter int unsigned U_DDS_ADDR_WIDTH = 7,
  parameter int unsigned U_DDS_CTRL_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [U_DDS_ADDR_WIDTH-1:0]   dds_addr,
  input  logic [U_DDS_DATA_WIDTH-1:0]   dds_data_I,
  output logic [U_DDS_DATA_WIDTH-1:0]   dds_data_O,
  output logic                          dds_data_T,
  input  logic [U_DDS_CTRL_WIDTH-1:0]   dds_control,
  input  logic                          dds_cs_n,
  input  logic                          dds_FUD,
  output logic [2*U_DDS_DATA_WIDTH-1:0] ftw,
  output logic [U_DDS_DATA_WIDTH-1:0]   ptw,
  output logic [U_DDS_DATA_WIDTH-1:0]   asf,
  output logic                          update_pulse,
  output logic                          proto_err,
  output logic [U_DDS_DATA_WIDTH-1:0]   wr_count
);

  localparam int unsigned IdxW  = U_DDS_ADDR_WIDTH - 1;
  localparam int unsigned Depth = 1 << IdxW;
  // Word indices of the tuning words (byte address >> 1).
  localparam int unsigned FtwHiIdx = 23;  // 0x2F
  localparam int unsigned FtwLoIdx = 22;  // 0x2D
  localparam int unsigned PtwIdx   = 24;  // 0x31
  localparam int unsigned AsfIdx   = 25;  // 0x33
  // Idle bus: dds_reset low, both strobes high.
  localparam logic [U_DDS_CTRL_WIDTH-1:0] CtrlIdle = U_DDS_CTRL_WIDTH'(3'b011);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRst} state_e;

  // Reset asserts asynchronously and releases two clocks later. Because the
  // synchronisers preload idle levels, the release cannot look like a bus edge.
  logic [1:0] rst_sync_q;
  logic       rst_core;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_core = rst_sync_q[1];

  // Two-flop synchronisers. Address bit 0 selects a byte lane that this bus does not use.
  logic [IdxW-1:0]             addr_m, s_addr;
  logic [U_DDS_DATA_WIDTH-1:0] data_m, s_data;
  logic [U_DDS_CTRL_WIDTH-1:0] ctrl_m, s_ctrl;
  logic                        cs_m, s_cs_n, fud_m, s_fud;
  logic                        w_prev, fud_prev;
  logic                        unused_addr_lsb;

  assign unused_addr_lsb = dds_addr[0];

  always_ff @(posedge clock or posedge rst_core) begin
    if (rst_core) begin
      addr_m   <= '0;
      s_addr   <= '0;
      data_m   <= '0;
      s_data   <= '0;
      ctrl_m   <= CtrlIdle;
      s_ctrl   <= CtrlIdle;
      cs_m     <= 1'b1;
      s_cs_n   <= 1'b1;
      fud_m    <= 1'b0;
      s_fud    <= 1'b0;
      w_prev   <= 1'b1;
      fud_prev <= 1'b0;
    end else begin
      addr_m   <= dds_addr[U_DDS_ADDR_WIDTH-1:1];
      s_addr   <= addr_m;
      data_m   <= dds_data_I;
      s_data   <= data_m;
      ctrl_m   <= dds_control;
      s_ctrl   <= ctrl_m;
      cs_m     <= dds_cs_n;
      s_cs_n   <= cs_m;
      fud_m    <= dds_FUD;
      s_fud    <= fud_m;
      w_prev   <= s_ctrl[0];
      fud_prev <= s_fud;
    end
  end

  state_e state_q;
  logic   s_dds_reset, s_r_strobe_n, s_w_strobe_n;
  logic   rst_req, both_low, wr_en, rd_start, copy;

  assign s_dds_reset  = s_ctrl[2];
  assign s_r_strobe_n = s_ctrl[1];
  assign s_w_strobe_n = s_ctrl[0];

  assign rst_req  = s_dds_reset & ~s_cs_n;
  assign both_low = ~s_r_strobe_n & ~s_w_strobe_n & ~s_cs_n;
  assign wr_en    = (state_q == StIdle) & ~rst_req & ~s_cs_n & s_r_strobe_n &
                    w_prev & ~s_w_strobe_n;
  assign rd_start = (state_q == StIdle) & ~rst_req & ~s_cs_n & s_w_strobe_n &
                    ~s_r_strobe_n;
  // A FUD edge is dropped while the banks are held in reset.
  assign copy     = s_fud & ~fud_prev & ~rst_req & (state_q != StRst);

  // Register banks. The active bank copies the post-write buffer, so a write
  // and a FUD edge on the same clock both take effect.
  logic [U_DDS_DATA_WIDTH-1:0] buffer_q [Depth];
  logic [U_DDS_DATA_WIDTH-1:0] buffer_d [Depth];
  logic [U_DDS_DATA_WIDTH-1:0] active_q [Depth];

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) buffer_d[i] = buffer_q[i];
    if (wr_en) buffer_d[s_addr] = s_data;
  end

  always_ff @(posedge clock or posedge rst_core) begin
    if (rst_core) begin
      for (int i = 0; i < int'(Depth); i++) begin
        buffer_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else if (state_q == StRst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        buffer_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        buffer_q[i] <= buffer_d[i];
        if (copy) active_q[i] <= buffer_d[i];
      end
    end
  end

  // Bus FSM. All bus-facing outputs are registered.
  always_ff @(posedge clock or posedge rst_core) begin
    if (rst_core) begin
      state_q      <= StIdle;
      dds_data_O   <= '0;
      dds_data_T   <= 1'b1;
      proto_err    <= 1'b0;
      wr_count     <= '0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= copy;
      dds_data_T   <= 1'b1;
      dds_data_O   <= '0;
      if (rst_req) begin
        state_q <= StRst;
      end else if (both_low) begin
        proto_err <= 1'b1;
        state_q   <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (wr_en) begin
              state_q <= StWrite;
              if (wr_count != '1) wr_count <= wr_count + 1'b1;
            end else if (rd_start) begin
              state_q    <= StRead;
              dds_data_T <= 1'b0;
              dds_data_O <= active_q[s_addr];
            end
          end
          // Deselect does not end a write; only the strobe release does.
          StWrite: if (s_w_strobe_n) state_q <= StIdle;
          StRead: begin
            if (s_r_strobe_n || s_cs_n) begin
              state_q <= StIdle;
            end else begin
              dds_data_T <= 1'b0;
              dds_data_O <= active_q[s_addr];
            end
          end
          StRst: if (!s_dds_reset) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
      if (state_q == StRst) begin
        wr_count  <= '0;
        proto_err <= 1'b0;
      end
    end
  end

  assign ftw = {active_q[FtwHiIdx], active_q[FtwLoIdx]};
  assign ptw = active_q[PtwIdx];
  assign asf = active_q[AsfIdx];

endmodule
